// File: rtl/shift_unit_seq_if.sv
// Handshake bundle for shift_unit_seq.
//   in_valid/in_ready  : operand handshake (in_data, in_amt, in_mode)
//   out_valid/out_ready: result handshake (out_data, out_carry, out_zero)
// master modport: the side that supplies operands and consumes results.
// slave modport : the shift unit itself.
interface shift_unit_seq_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: LSR / ASR / LSL / ROR on a WIDTH-bit operand,
// one bit position per clock, with carry-out and zero flags.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_unit_seq_if.slave (operand and result handshakes)
module shift_unit_seq #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  shift_unit_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH) + 1;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;
  logic [SHW-1:0]   cnt_q;
  logic             carry_q;
  logic             zero_q;
  logic             valid_q;

  logic [SHW-1:0]   n_next;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // One bit-position step; the carry-out sits in the MSB of the result.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0]       mode,
                                                input logic [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH:0]          r;
    sd = d;
    case (mode)
      MODE_LSR: r = {d[0], 1'b0, d[WIDTH-1:1]};
      MODE_ASR: r = {d[0], sd >>> 1};
      MODE_LSL: r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      default:  r = {d[0], d[0], d[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Rotations repeat every WIDTH steps; the other modes saturate at WIDTH,
  // which already yields the fully shifted-out result and the right carry.
  always_comb begin
    n_next = bus.in_amt;
    if (bus.in_mode == 2'b11) begin
      n_next = bus.in_amt % SHW'(WIDTH);
    end else if (bus.in_amt > SHW'(WIDTH)) begin
      n_next = SHW'(WIDTH);
    end
  end

  assign {step_carry, step_data} = shift_step(mode_q, data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q  <= bus.in_data;
            zero_q  <= (bus.in_data == '0);
            mode_q  <= bus.in_mode;
            cnt_q   <= n_next;
            carry_q <= 1'b0;
            state   <= (n_next == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_q  <= step_data;
          zero_q  <= (step_data == '0);
          carry_q <= step_carry;
          cnt_q   <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // out_valid is registered one cycle after the result settles,
          // so it never depends combinationally on anything but state.
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_carry = carry_q;
  assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq (WIDTH = 8): directed cases plus
// randomized operations, with a scoreboard queue and an independent monitor.
module tb_shift_unit_seq;
  localparam int W = 8;

  logic clk;
  logic rst_n;

  shift_unit_seq_if #(.WIDTH(W)) bus ();

  shift_unit_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int data;
    int carry;
    int zero;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   ready_mode;   // 0: always ready, 1: random, 2: held low
  bit   seen;
  bit   post_hs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference behaviour from the operation definitions, in integer arithmetic.
  function automatic exp_t model(input int d, input int amt, input int m);
    exp_t e;
    int   k, sv, r, c;
    sv = (d >= 128) ? d - 256 : d;
    k  = (amt > W) ? W : amt;
    case (m)
      0: begin r = d >> k;           c = (k == 0) ? 0 : (d >> (k - 1)) & 1; end
      1: begin r = (sv >>> k) & 255; c = (k == 0) ? 0 : (sv >>> (k - 1)) & 1; end
      2: begin r = (d << k) & 255;   c = (k == 0) ? 0 : (d >> (W - k)) & 1; end
      default: begin
        k = amt % W;
        r = ((d >> k) | (d << (W - k))) & 255;
        c = (k == 0) ? 0 : (d >> (k - 1)) & 1;
      end
    endcase
    e.data = r; e.carry = c; e.zero = (r == 0) ? 1 : 0; e.lat = k + 1; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input int d, input int c, input int z, input int l);
    exp_t e;
    e.data = d; e.carry = c; e.zero = z; e.lat = l; e.acc = 0;
    return e;
  endfunction

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented result cycle against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen    = 1'b0;
      post_hs = 1'b0;
    end else begin
      if (post_hs) begin
        chk("in_ready_after_hs", bus.in_ready, 1);
        chk("out_valid_after_hs", bus.out_valid, 0);
        post_hs = 1'b0;
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc - sb[0].acc, sb[0].lat);
          end
          chk("out_data", bus.out_data, sb[0].data);
          chk("out_carry", bus.out_carry, sb[0].carry);
          chk("out_zero", bus.out_zero, sb[0].zero);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            seen    = 1'b0;
            post_hs = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input int d, input int a, input int m, input exp_t e,
                       input bit check_ready);
    int guard;
    int k;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d[7:0];
    bus.in_amt   = a[3:0];
    bus.in_mode  = m[1:0];
    e.acc = cyc + 1;
    sb.push_back(e);
    k = e.lat - 1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_amt   = 4'($urandom);
    bus.in_mode  = 2'($urandom);
    @(negedge clk);
    chk("in_ready_busy", bus.in_ready, 0);
    if (check_ready) begin
      repeat (k + 1) begin
        @(negedge clk);
        chk("in_ready_busy", bus.in_ready, 0);
      end
      @(negedge clk);
      chk("in_ready_return", bus.in_ready, 1);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int d, a, m, guard;
    checks = 0; errors = 0; cyc = 0; ready_mode = 0;
    seen = 1'b0; post_hs = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_mode = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_carry", bus.out_carry, 0);
    chk("rst_out_zero", bus.out_zero, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with literal expected results.
    issue(8'hB4, 3,  0, mk(8'h16, 1, 0, 4), 1'b1);
    issue(8'h96, 2,  1, mk(8'hE5, 1, 0, 3), 1'b1);
    issue(8'h80, 15, 1, mk(8'hFF, 1, 0, 9), 1'b1);
    issue(8'h81, 1,  2, mk(8'h02, 1, 0, 2), 1'b1);
    issue(8'h81, 12, 2, mk(8'h00, 1, 1, 9), 1'b1);
    issue(8'h01, 9,  3, mk(8'h80, 1, 0, 2), 1'b1);
    issue(8'h3C, 8,  3, mk(8'h3C, 0, 0, 1), 1'b1);
    issue(8'h5A, 0,  2, mk(8'h5A, 0, 0, 1), 1'b1);
    issue(8'hB4, 9,  0, mk(8'h00, 1, 1, 9), 1'b1);
    drain();

    // Stall in DONE: result frozen, in_ready stays low.
    ready_mode = 2;
    issue(8'h5A, 0, 1, mk(8'h5A, 0, 0, 1), 1'b0);
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("stall_out_valid", bus.out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
    end
    ready_mode = 0;
    drain();

    // Reset in the middle of a shift aborts it.
    issue(8'hFF, 7, 0, mk(8'h01, 1, 0, 8), 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_data", bus.out_data, 0);
    chk("abort_out_zero", bus.out_zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_result", bus.out_valid, 0);
    end
    issue(8'hF0, 4, 0, mk(8'h0F, 0, 0, 5), 1'b1);
    drain();

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      d = $urandom_range(0, 255); a = $urandom_range(0, 15); m = $urandom_range(0, 3);
      issue(d, a, m, model(d, a, m), 1'b1);
    end
    ready_mode = 1;
    for (int i = 0; i < 120; i++) begin
      d = $urandom_range(0, 255); a = $urandom_range(0, 15); m = $urandom_range(0, 3);
      issue(d, a, m, model(d, a, m), 1'b0);
    end
    ready_mode = 0;
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised, multi-cycle shift unit for the ALU datapath. It supports logical right, arithmetic right, logical left and rotate right on a WIDTH-bit operand, one bit position per clock. Shift amounts at or beyond WIDTH are clipped. Operands arrive over a valid/ready handshake, and results leave over one, with carry-out and zero flags.

## Interface
- WIDTH, default 8: operand width, must be ≥ 2.
- SHW, default $clog2(WIDTH)+1: shift-amount width. It is derived and not overridden.
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: operand valid.
- in_ready  out  1: unit can accept. High only in IDLE.
- in_data  in  WIDTH: operand.
- in_amt  in  SHW: shift amount, unsigned.
- in_mode  in  2: operation select.
  - 00: logical right (LSR).
  - 01: arithmetic right (ASR).
  - 10: logical left (LSL).
  - 11: rotate right (ROR).
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- out_data  out  WIDTH: shifted result.
- out_carry  out  1: last bit shifted or rotated out. 0 if no step was taken.
- out_zero  out  1: out_data == 0.

One clock; reset is asynchronous and active-low, ports clk and rst_n.

## Operation
- FSM states: IDLE, SHIFT, DONE. All state and output registers clear asynchronously on rst_n low.
- Reset values:
  - State is IDLE, so in_ready = 1.
  - out_valid = 0, out_data = 0, out_carry = 0, out_zero = 1.
- Accept: in_valid && in_ready at a rising edge.
  - Latches in_data, in_mode and the step count n.
  - Clears carry.
- Step count n:
  - LSR, ASR and LSL: n = min(in_amt, WIDTH).
  - ROR: n = in_amt mod WIDTH.
- Next state after accept: DONE if n == 0, else SHIFT.
- Each SHIFT cycle performs one step and decrements n. The move to DONE happens on the edge that performs the final step.
  - LSR: carry ← d[0]; d ← {0, d[W-1:1]}.
  - ASR: carry ← d[0]; d ← {d[W-1], d[W-1:1]}.
  - LSL: carry ← d[W-1]; d ← {d[W-2:0], 0}.
  - ROR: carry ← d[0]; d ← {d[0], d[W-1:1]}.
- Clipped amounts: because n is clipped to WIDTH, out_carry for in_amt > WIDTH equals the bit removed on step WIDTH.
  - LSR: the original MSB.
  - LSL: the original LSB.
  - ASR: the sign bit.
- Results for shifts of WIDTH or more: LSR and LSL give 0; ASR gives all sign bits.
- DONE:
  - out_valid = 1. out_data, out_carry and out_zero are held stable until out_valid && out_ready.
  - On that edge the unit returns to IDLE and out_valid drops.
- Input changes while the unit is not in IDLE are ignored. The inputs are sampled only at accept.
- out_zero is registered together with out_data.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. No result is produced.

## Timing
- Accept at edge E0:
  - n == 0: out_valid is high after edge E0+1.
  - n > 0: out_valid is high after edge E0+n+1.
- in_ready falls after E0 and rises the cycle after the output handshake edge.
- No overlap: a new accept can occur no earlier than the edge after the output handshake.
- Peak throughput is one operation per n+3 cycles.
- out_ready held low stalls the unit indefinitely in DONE, with outputs frozen.
- in_ready, out_valid and out_* are decoded from registered state, with no combinational path from in_* or out_ready. in_ready reads 1 while rst_n is low.

## Test plan
All scenarios use WIDTH = 8.
1. LSR: in_data 0xB4, amt 3, out_ready = 1 → out_data 0x16, out_carry 1, out_zero 0. out_valid appears 4 cycles after accept.
2. ASR: 0x96, amt 2 → 0xE5, carry 1. ASR 0x80, amt 15 → 0xFF, carry 1, latency 9 (clipped to 8 steps).
3. LSL: 0x81, amt 1 → 0x02, carry 1. LSL 0x81, amt 12 → 0x00, carry 1, out_zero 1.
4. ROR: 0x01, amt 9 → 0x80, carry 1. ROR 0x3C, amt 8 → 0x3C, carry 0, out_valid 1 cycle after accept.
5. Amount 0, any mode: 0x5A → 0x5A, carry 0, in_ready low 2 cycles. Hold out_ready low 5 cycles → out_data stable, in_ready 0 throughout, then in_ready 1 the cycle after the handshake.
6. Pulse rst_n low during SHIFT of LSR 0xFF, amt 7 → out_valid 0, in_ready 1 and no result emitted. The next operation behaves normally: LSR 0xF0, amt 4 → 0x0F.
